// File: rtl/mpsoc_wb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : mpsoc_wb_uart_transmitter
// Brief    : UART transmit path: 16-entry byte FIFO feeding an LCR-framed
//            serializer paced by the 16x baud enable.
// Revision : 1.0 - initial release
// ============================================================================
module mpsoc_wb_uart_transmitter #(
    parameter int FIFO_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_POINTER_W = 4,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      enable,
    input  logic [7:0]                lcr,
    input  logic                      tx_push,
    input  logic [FIFO_WIDTH-1:0]     tx_data,
    input  logic                      tx_fifo_reset,
    input  logic                      reset_status,
    output logic                      stx_pad_o,
    output logic [2:0]                tstate,
    output logic [FIFO_COUNTER_W-1:0] tf_count,
    output logic                      tx_overrun,
    output logic                      tx_empty
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [FIFO_COUNTER_W-1:0] c_full      = FIFO_COUNTER_W'(FIFO_DEPTH);
    localparam logic [4:0]                c_bit_ticks = 5'd15;
    localparam logic [4:0]                c_stop_1p5  = 5'd23;
    localparam logic [4:0]                c_stop_2    = 5'd31;

    logic [FIFO_WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [FIFO_POINTER_W-1:0] r_top;
    logic [FIFO_POINTER_W-1:0] r_bottom;
    logic [FIFO_COUNTER_W-1:0] r_count;
    logic                      r_overrun;

    state_t                r_state,    w_state_nxt;
    logic [4:0]            r_timer,    w_timer_nxt;
    logic [FIFO_WIDTH-1:0] r_shift,    w_shift_nxt;
    logic [2:0]            r_bits,     w_bits_nxt;
    logic [1:0]            r_wlen,     w_wlen_nxt;
    logic                  r_stop_sel, w_stop_sel_nxt;
    logic                  r_par_en,   w_par_en_nxt;
    logic                  r_par_bit,  w_par_bit_nxt;
    logic                  r_line,     w_line_nxt;

    logic                  w_pop;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_drop;
    logic                  w_bit_end;
    logic [FIFO_WIDTH-1:0] w_head;
    logic [FIFO_WIDTH-1:0] w_mask;
    logic                  w_par_xor;
    logic                  w_par_calc;
    logic [4:0]            w_stop_len;
    logic                  w_unused;

    assign w_unused = lcr[7];

    // A full FIFO still accepts a push when the serializer pops in the same cycle.
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_full    = (r_count == c_full);
    assign w_push_ok = tx_push && (!w_full || w_pop);
    assign w_drop    = tx_push && w_full && !w_pop;
    assign w_head    = r_mem[r_bottom];

    assign w_mask     = FIFO_WIDTH'(8'hFF >> (2'd3 - lcr[1:0]));
    assign w_par_xor  = ^(w_head & w_mask);
    assign w_par_calc = lcr[5] ? ~lcr[4] : (lcr[4] ? w_par_xor : ~w_par_xor);

    assign w_bit_end  = enable && (r_timer == 5'd0);
    assign w_stop_len = !r_stop_sel ? c_bit_ticks : ((r_wlen == 2'd0) ? c_stop_1p5 : c_stop_2);

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_top    <= '0;
            r_bottom <= '0;
            r_count  <= '0;
        end else if (tx_fifo_reset) begin
            r_top    <= '0;
            r_bottom <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_top    <= r_top + 1'b1;
            if (w_pop)     r_bottom <= r_bottom + 1'b1;
            r_count <= r_count + FIFO_COUNTER_W'(w_push_ok) - FIFO_COUNTER_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !tx_fifo_reset) r_mem[r_top] <= tx_data;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i)                          r_overrun <= 1'b0;
        else if (w_drop)                       r_overrun <= 1'b1;
        else if (tx_fifo_reset || reset_status) r_overrun <= 1'b0;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_shift    <= '0;
            r_bits     <= '0;
            r_wlen     <= '0;
            r_stop_sel <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_line     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_shift    <= w_shift_nxt;
            r_bits     <= w_bits_nxt;
            r_wlen     <= w_wlen_nxt;
            r_stop_sel <= w_stop_sel_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_line     <= w_line_nxt;
        end
    end

    // Line level is decided on the transition so it is stable for the whole bit.
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_shift_nxt    = r_shift;
        w_bits_nxt     = r_bits;
        w_wlen_nxt     = r_wlen;
        w_stop_sel_nxt = r_stop_sel;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_line_nxt     = r_line;
        if (enable && (r_timer != 5'd0)) w_timer_nxt = r_timer - 5'd1;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt    = S_START;
                    w_timer_nxt    = c_bit_ticks;
                    w_shift_nxt    = w_head;
                    w_bits_nxt     = 3'd0;
                    w_wlen_nxt     = lcr[1:0];
                    w_stop_sel_nxt = lcr[2];
                    w_par_en_nxt   = lcr[3];
                    w_par_bit_nxt  = w_par_calc;
                    w_line_nxt     = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_timer_nxt = c_bit_ticks;
                    w_line_nxt  = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_timer_nxt = c_bit_ticks;
                    if (r_bits == (3'd4 + {1'b0, r_wlen})) begin
                        if (r_par_en) begin
                            w_state_nxt = S_PARITY;
                            w_line_nxt  = r_par_bit;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_timer_nxt = w_stop_len;
                            w_line_nxt  = 1'b1;
                        end
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_bits_nxt  = r_bits + 3'd1;
                        w_line_nxt  = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_timer_nxt = w_stop_len;
                    w_line_nxt  = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                    w_line_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_line_nxt  = 1'b1;
            end
        endcase
    end

    assign stx_pad_o  = r_line & ~lcr[6];
    assign tstate     = r_state;
    assign tf_count   = r_count;
    assign tx_overrun = r_overrun;
    assign tx_empty   = (r_count == '0) && (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mpsoc_wb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpsoc_wb_uart_transmitter
// Brief    : Frame-level reference model plus directed and random stimulus
//            for the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpsoc_wb_uart_transmitter;

    logic       clk           = 1'b0;
    logic       wb_rst_i      = 1'b1;
    logic       enable        = 1'b0;
    logic [7:0] lcr           = 8'h03;
    logic       tx_push       = 1'b0;
    logic [7:0] tx_data       = 8'h00;
    logic       tx_fifo_reset = 1'b0;
    logic       reset_status  = 1'b0;
    logic       stx_pad_o;
    logic [2:0] tstate;
    logic [4:0] tf_count;
    logic       tx_overrun;
    logic       tx_empty;

    int errors  = 0;
    int checks  = 0;
    int en_mode = 0;
    int cyc     = 0;
    int n;

    mpsoc_wb_uart_transmitter dut (
        .clk           (clk),
        .wb_rst_i      (wb_rst_i),
        .enable        (enable),
        .lcr           (lcr),
        .tx_push       (tx_push),
        .tx_data       (tx_data),
        .tx_fifo_reset (tx_fifo_reset),
        .reset_status  (reset_status),
        .stx_pad_o     (stx_pad_o),
        .tstate        (tstate),
        .tf_count      (tf_count),
        .tx_overrun    (tx_overrun),
        .tx_empty      (tx_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the current frame is a list of (level, state code, length in enables).
    logic [7:0] m_q[$];
    logic       m_busy = 1'b0;
    logic       m_ovr  = 1'b0;
    logic       m_drop;
    int         m_idx  = 0;
    int         m_rem  = 0;
    int         m_nseg = 0;
    logic       m_lvl[12];
    int         m_st[12];
    int         m_dur[12];

    function automatic void build(input logic [7:0] d, input logic [7:0] l);
        int nb   = 5 + int'(l[1:0]);
        int ones = 0;
        m_lvl[0] = 1'b0; m_st[0] = 1; m_dur[0] = 16; m_nseg = 1;
        for (int i = 0; i < nb; i++) begin
            m_lvl[m_nseg] = d[i]; m_st[m_nseg] = 2; m_dur[m_nseg] = 16; m_nseg++;
            ones += int'(d[i]);
        end
        if (l[3]) begin
            if (l[5])      m_lvl[m_nseg] = !l[4];
            else if (l[4]) m_lvl[m_nseg] = (ones % 2) == 1;
            else           m_lvl[m_nseg] = (ones % 2) == 0;
            m_st[m_nseg] = 3; m_dur[m_nseg] = 16; m_nseg++;
        end
        m_lvl[m_nseg] = 1'b1; m_st[m_nseg] = 4;
        m_dur[m_nseg] = !l[2] ? 16 : ((nb == 5) ? 24 : 32);
        m_nseg++;
        m_busy = 1'b1; m_idx = 0; m_rem = m_dur[0];
    endfunction

    initial forever begin
        @(posedge clk or posedge wb_rst_i);
        if (wb_rst_i) begin
            m_q.delete(); m_busy = 1'b0; m_ovr = 1'b0; m_idx = 0;
        end else begin
            if (m_busy) begin
                if (enable) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_idx++;
                        if (m_idx == m_nseg) m_busy = 1'b0;
                        else                 m_rem  = m_dur[m_idx];
                    end
                end
            end else if (m_q.size() != 0) begin
                build(m_q.pop_front(), lcr);
            end
            m_drop = tx_push && (m_q.size() >= 16);
            if (tx_fifo_reset)          m_q.delete();
            else if (tx_push && !m_drop) m_q.push_back(tx_data);
            if (m_drop)                             m_ovr = 1'b1;
            else if (tx_fifo_reset || reset_status) m_ovr = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk); #2;
        chk("cmp_stx",    stx_pad_o, (m_busy ? m_lvl[m_idx] : 1'b1) & !lcr[6]);
        chk("cmp_tstate", tstate, m_busy ? m_st[m_idx] : 0);
        chk("cmp_count",  tf_count, m_q.size());
        chk("cmp_ovr",    tx_overrun, m_ovr);
        chk("cmp_empty",  tx_empty, !m_busy && (m_q.size() == 0));
    end

    initial forever begin
        @(negedge clk); #1;
        cyc++;
        case (en_mode)
            0:       enable = 1'b1;
            1:       enable = (cyc % 4 == 0);
            2:       enable = 1'b0;
            default: enable = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic push(input logic [7:0] d);
        tx_push = 1'b1; tx_data = d;
        @(negedge clk);
        tx_push = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int k = 0;
        while (tx_empty !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        chk(nm, tx_empty, 1);
    endtask

    task automatic wait_state(input string nm, input logic [2:0] s, input int bound);
        int k = 0;
        while (tstate !== s && k < bound) begin @(negedge clk); k++; end
        chk(nm, tstate, s);
    endtask

    task automatic frame_check(input string nm, input logic [7:0] l, input logic [7:0] d,
                               input logic [9:0] exp);
        wait_empty({nm, "_idle"});
        lcr = l;
        push(d);
        chk({nm, "_cnt1"},  tf_count, 1);
        chk({nm, "_pre"},   tstate, 0);
        @(negedge clk);
        chk({nm, "_start"}, tstate, 1);
        chk({nm, "_line0"}, stx_pad_o, 0);
        chk({nm, "_cnt0"},  tf_count, 0);
        chk({nm, "_busy"},  tx_empty, 0);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("%s_bit%0d", nm, k), stx_pad_o, exp[k]);
            repeat (16) @(negedge clk);
        end
        chk({nm, "_done"}, tx_empty, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_line",  stx_pad_o, 1);
        chk("rst_state", tstate, 0);
        chk("rst_cnt",   tf_count, 0);
        chk("rst_ovr",   tx_overrun, 0);
        chk("rst_empty", tx_empty, 1);
        wb_rst_i = 1'b0;
        @(negedge clk);

        // 8N1 0xA5 and 7-bit even / stick parity 0x35
        frame_check("8n1", 8'h03, 8'hA5, 10'h34A);
        frame_check("7e1", 8'h1A, 8'h35, 10'h26A);
        frame_check("7s1", 8'h3A, 8'h35, 10'h26A);

        // 5 data bits, 1.5 stop, enable every 4th cycle
        wait_empty("5n15_idle");
        en_mode = 1; lcr = 8'h04;
        push(8'h1B);
        wait_state("5n15_stop", 3'd4, 2000);
        n = 0;
        while (tstate == 3'd4 && n < 400) begin @(negedge clk); n++; end
        chk("5n15_stop_cycles", n, 96);

        // Overrun with the baud enable stopped
        en_mode = 0;
        wait_empty("ovr_idle");
        en_mode = 2; lcr = 8'h03;
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            tx_push = 1'b1; tx_data = 8'(8'h40 + i);
            @(negedge clk);
        end
        tx_push = 1'b0;
        chk("ovr_cnt",   tf_count, 16);
        chk("ovr_flag",  tx_overrun, 1);
        chk("ovr_state", tstate, 1);
        reset_status = 1'b1; @(negedge clk); reset_status = 1'b0;
        chk("ovr_clr",      tx_overrun, 0);
        chk("ovr_cnt_keep", tf_count, 16);
        tx_fifo_reset = 1'b1; @(negedge clk); tx_fifo_reset = 1'b0;
        chk("fr_cnt",   tf_count, 0);
        chk("fr_state", tstate, 1);
        en_mode = 0;

        // Back-to-back frames, then FIFO clear mid-frame
        wait_empty("b2b_idle");
        lcr = 8'h03;
        push(8'h00); push(8'hFF);
        wait_state("b2b_stop", 3'd4, 400);
        n = 0;
        while (tstate == 3'd4 && n < 40) begin @(negedge clk); n++; end
        chk("b2b_gap_state", tstate, 0);
        chk("b2b_gap_cnt",   tf_count, 1);
        @(negedge clk);
        chk("b2b_start2", tstate, 1);
        chk("b2b_line2",  stx_pad_o, 0);
        repeat (40) @(negedge clk);
        push(8'h12); push(8'h34);
        chk("fr2_cnt", tf_count, 2);
        tx_fifo_reset = 1'b1; @(negedge clk); tx_fifo_reset = 1'b0;
        chk("fr2_cnt0",  tf_count, 0);
        chk("fr2_still", tstate, 2);
        wait_empty("fr2_done");

        // Break mid-DATA, then asynchronous reset mid-DATA
        push(8'h5A);
        wait_state("brk_data", 3'd2, 100);
        repeat (20) @(negedge clk);
        lcr = 8'h43; #1;
        chk("brk_line",  stx_pad_o, 0);
        chk("brk_state", tstate, 2);
        repeat (5) @(negedge clk);
        chk("brk_hold", stx_pad_o, 0);
        lcr = 8'h03; #1;
        chk("brk_release", stx_pad_o, 1);
        @(negedge clk);
        push(8'h11); push(8'h22);
        chk("rst_pre_cnt", tf_count, 2);
        wb_rst_i = 1'b1; #1;
        chk("arst_line",  stx_pad_o, 1);
        chk("arst_state", tstate, 0);
        chk("arst_cnt",   tf_count, 0);
        chk("arst_empty", tx_empty, 1);
        @(negedge clk);
        wb_rst_i = 1'b0;

        // Random traffic: LCR churn, pushes into a full FIFO, status clears
        en_mode = 3;
        for (int c = 0; c < 20000; c++) begin
            tx_push = ($urandom_range(0, 99) < 10);
            tx_data = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                lcr    = 8'($urandom);
                lcr[6] = ($urandom_range(0, 15) == 0);
            end
            reset_status  = ($urandom_range(0, 299) == 0);
            tx_fifo_reset = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        tx_push = 1'b0; reset_status = 1'b0; tx_fifo_reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
